// File: rtl/shift_unit.sv
// Multi-cycle variable shifter: SLL/SRL/SRA/ROL of a registered operand,
// up to STEP bits per cycle, under a start/busy/done handshake.
module shift_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out,
  output logic               carry,
  output logic [1:0]         state_dbg
);

  // Handshake: start is accepted only while IDLE; busy is high from the
  // accept edge until done rises; done is a one-cycle pulse marking out/carry valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  state_e               state_q;
  logic [WIDTH-1:0]     reg_q;
  logic [WIDTH-1:0]     reg_d;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [SHAMT_W-1:0]   cnt_d;
  logic [1:0]           mode_q;
  logic                 carry_q;
  logic                 carry_d;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     out_q;

  // One SHIFT cycle: apply min(STEP, cnt) single-bit steps in sequence.
  always_comb begin
    reg_d   = reg_q;
    carry_d = carry_q;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(cnt_q)) begin
        case (mode_q)
          MODE_SLL: begin
            carry_d = reg_d[WIDTH-1];
            reg_d   = {reg_d[WIDTH-2:0], 1'b0};
          end
          MODE_SRL: begin
            carry_d = reg_d[0];
            reg_d   = {1'b0, reg_d[WIDTH-1:1]};
          end
          MODE_SRA: begin
            carry_d = reg_d[0];
            reg_d   = {reg_d[WIDTH-1], reg_d[WIDTH-1:1]};
          end
          MODE_ROL: begin
            carry_d = reg_d[WIDTH-1];
            reg_d   = {reg_d[WIDTH-2:0], reg_d[WIDTH-1]};
          end
          default: begin
            carry_d = carry_q;
            reg_d   = reg_q;
          end
        endcase
      end
    end
    if (int'(cnt_q) > STEP) begin
      cnt_d = cnt_q - SHAMT_W'(STEP);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      reg_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_SLL;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            reg_q   <= in;
            cnt_q   <= shamt;
            mode_q  <= mode;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (shamt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          reg_q   <= reg_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_d;
          if (cnt_d == '0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          out_q   <= reg_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out       = out_q;
  assign carry     = carry_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: one STEP=1 and one STEP=4 instance,
// each scenario task checks its own results inline.
module tb_shift_unit;

  logic        clk;
  logic        reset;
  logic        start1;
  logic        start4;
  logic [1:0]  mode;
  logic [15:0] din;
  logic [3:0]  shamt;

  logic        busy1, done1, carry1;
  logic [15:0] out1;
  logic [1:0]  st1;
  logic        busy4, done4, carry4;
  logic [15:0] out4;
  logic [1:0]  st4;

  logic        sel4;
  logic        busy_m, done_m, carry_m;
  logic [15:0] out_m;

  int          n_checks;
  int          n_fail;
  int          cyc;

  shift_unit #(.WIDTH(16), .SHAMT_W(4), .STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode), .in(din),
    .shamt(shamt), .busy(busy1), .done(done1), .out(out1), .carry(carry1),
    .state_dbg(st1)
  );

  shift_unit #(.WIDTH(16), .SHAMT_W(4), .STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .mode(mode), .in(din),
    .shamt(shamt), .busy(busy4), .done(done4), .out(out4), .carry(carry4),
    .state_dbg(st4)
  );

  assign busy_m  = sel4 ? busy4  : busy1;
  assign done_m  = sel4 ? done4  : done1;
  assign out_m   = sel4 ? out4   : out1;
  assign carry_m = sel4 ? carry4 : carry1;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Driver: issue one operation, scramble inputs after accept, wait for done.
  task automatic do_op(input bit s4, input logic [1:0] m, input logic [15:0] d,
                       input logic [3:0] sa, output logic [15:0] o,
                       output logic c, output int lat, output int bcnt,
                       output int acc);
    sel4  = s4;
    mode  = m;
    din   = d;
    shamt = sa;
    if (s4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    acc    = cyc;
    start1 = 1'b0;
    start4 = 1'b0;
    mode   = 2'($urandom_range(0, 3));
    din    = 16'($urandom_range(0, 65535));
    shamt  = 4'($urandom_range(0, 15));
    lat  = -1;
    bcnt = busy_m ? 1 : 0;
    o    = 'x;
    c    = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done_m) begin
        lat = i;
        o   = out_m;
        c   = carry_m;
        break;
      end
      if (busy_m) bcnt++;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    mode   = 2'b00;
    din    = 16'h0;
    shamt  = 4'h0;
    sel4   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 4;
    if (busy1 !== 1'b0)   begin n_fail++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    if (done1 !== 1'b0)   begin n_fail++; $display("FAIL reset_done1 got %b want 0", done1); end
    if (out1 !== 16'h0)   begin n_fail++; $display("FAIL reset_out1 got %h want 0000", out1); end
    if (carry1 !== 1'b0)  begin n_fail++; $display("FAIL reset_carry1 got %b want 0", carry1); end
    n_checks += 4;
    if (busy4 !== 1'b0)   begin n_fail++; $display("FAIL reset_busy4 got %b want 0", busy4); end
    if (done4 !== 1'b0)   begin n_fail++; $display("FAIL reset_done4 got %b want 0", done4); end
    if (out4 !== 16'h0)   begin n_fail++; $display("FAIL reset_out4 got %h want 0000", out4); end
    if (carry4 !== 1'b0)  begin n_fail++; $display("FAIL reset_carry4 got %b want 0", carry4); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sll_basic();
    logic [15:0] o; logic c; int lat, bc, acc;
    do_op(1'b0, 2'b00, 16'h0001, 4'd1, o, c, lat, bc, acc);
    n_checks += 4;
    if (o !== 16'h0002) begin n_fail++; $display("FAIL sll1_out got %h want 0002", o); end
    if (c !== 1'b0)     begin n_fail++; $display("FAIL sll1_carry got %b want 0", c); end
    if (lat != 2)       begin n_fail++; $display("FAIL sll1_latency got %0d want 2", lat); end
    if (bc != 2)        begin n_fail++; $display("FAIL sll1_busy_cycles got %0d want 2", bc); end
    @(posedge clk);
    #1;
    n_checks++;
    if (done1 !== 1'b0) begin n_fail++; $display("FAIL sll1_done_pulse got %b want 0", done1); end
  endtask

  task automatic test_sra();
    logic [15:0] o; logic c; int lat, bc, acc;
    do_op(1'b0, 2'b10, 16'h8000, 4'd15, o, c, lat, bc, acc);
    n_checks += 3;
    if (o !== 16'hFFFF) begin n_fail++; $display("FAIL sra15_out got %h want ffff", o); end
    if (c !== 1'b0)     begin n_fail++; $display("FAIL sra15_carry got %b want 0", c); end
    if (lat != 16)      begin n_fail++; $display("FAIL sra15_latency got %0d want 16", lat); end
  endtask

  task automatic test_rol_srl();
    logic [15:0] o; logic c; int lat, bc, acc;
    do_op(1'b0, 2'b11, 16'h8001, 4'd4, o, c, lat, bc, acc);
    n_checks += 3;
    if (o !== 16'h0018) begin n_fail++; $display("FAIL rol4_out got %h want 0018", o); end
    if (c !== 1'b0)     begin n_fail++; $display("FAIL rol4_carry got %b want 0", c); end
    if (lat != 5)       begin n_fail++; $display("FAIL rol4_latency got %0d want 5", lat); end
    do_op(1'b0, 2'b01, 16'h0018, 4'd4, o, c, lat, bc, acc);
    n_checks += 2;
    if (o !== 16'h0001) begin n_fail++; $display("FAIL srl4_out got %h want 0001", o); end
    if (c !== 1'b1)     begin n_fail++; $display("FAIL srl4_carry got %b want 1", c); end
    do_op(1'b0, 2'b11, 16'hC000, 4'd1, o, c, lat, bc, acc);
    n_checks += 2;
    if (o !== 16'h8001) begin n_fail++; $display("FAIL rol1_out got %h want 8001", o); end
    if (c !== 1'b1)     begin n_fail++; $display("FAIL rol1_carry got %b want 1", c); end
  endtask

  task automatic test_zero_shamt();
    logic [15:0] o; logic c; int lat, bc, acc;
    do_op(1'b0, 2'b00, 16'hA5A5, 4'd0, o, c, lat, bc, acc);
    n_checks += 3;
    if (o !== 16'hA5A5) begin n_fail++; $display("FAIL zero_out got %h want a5a5", o); end
    if (c !== 1'b0)     begin n_fail++; $display("FAIL zero_carry got %b want 0", c); end
    if (lat != 1)       begin n_fail++; $display("FAIL zero_latency got %0d want 1", lat); end
  endtask

  task automatic test_start_while_busy();
    int ndone;
    logic [15:0] o;
    sel4   = 1'b0;
    mode   = 2'b00;
    din    = 16'h0101;
    shamt  = 4'd3;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    mode  = 2'b01;
    din   = 16'hFFFF;
    shamt = 4'd1;
    ndone = 0;
    o     = 'x;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) start1 = 1'b0;
      if (done1) begin
        ndone++;
        o = out1;
      end
    end
    n_checks += 2;
    if (ndone != 1)     begin n_fail++; $display("FAIL held_start_dones got %0d want 1", ndone); end
    if (o !== 16'h0808) begin n_fail++; $display("FAIL held_start_out got %h want 0808", o); end
  endtask

  task automatic test_step4();
    logic [15:0] o; logic c; int lat, bc, acc;
    do_op(1'b1, 2'b00, 16'h0001, 4'd5, o, c, lat, bc, acc);
    n_checks += 3;
    if (o !== 16'h0020) begin n_fail++; $display("FAIL s4_sll5_out got %h want 0020", o); end
    if (c !== 1'b0)     begin n_fail++; $display("FAIL s4_sll5_carry got %b want 0", c); end
    if (lat != 3)       begin n_fail++; $display("FAIL s4_sll5_latency got %0d want 3", lat); end
    do_op(1'b1, 2'b01, 16'hFFFF, 4'd15, o, c, lat, bc, acc);
    n_checks += 3;
    if (o !== 16'h0001) begin n_fail++; $display("FAIL s4_srl15_out got %h want 0001", o); end
    if (c !== 1'b1)     begin n_fail++; $display("FAIL s4_srl15_carry got %b want 1", c); end
    if (lat != 5)       begin n_fail++; $display("FAIL s4_srl15_latency got %0d want 5", lat); end
    do_op(1'b1, 2'b10, 16'h9000, 4'd6, o, c, lat, bc, acc);
    n_checks += 2;
    if (o !== 16'hFE40) begin n_fail++; $display("FAIL s4_sra6_out got %h want fe40", o); end
    if (c !== 1'b0)     begin n_fail++; $display("FAIL s4_sra6_carry got %b want 0", c); end
  endtask

  task automatic test_abort();
    int ndone;
    logic [15:0] o; logic c; int lat, bc, acc;
    sel4   = 1'b0;
    mode   = 2'b01;
    din    = 16'hF0F0;
    shamt  = 4'd10;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks += 4;
    if (busy1 !== 1'b0)  begin n_fail++; $display("FAIL abort_busy got %b want 0", busy1); end
    if (done1 !== 1'b0)  begin n_fail++; $display("FAIL abort_done got %b want 0", done1); end
    if (out1 !== 16'h0)  begin n_fail++; $display("FAIL abort_out got %h want 0000", out1); end
    if (carry1 !== 1'b0) begin n_fail++; $display("FAIL abort_carry got %b want 0", carry1); end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done1) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin n_fail++; $display("FAIL abort_late_done got %0d want 0", ndone); end
    do_op(1'b0, 2'b00, 16'h0003, 4'd2, o, c, lat, bc, acc);
    n_checks += 3;
    if (o !== 16'h000C) begin n_fail++; $display("FAIL post_abort_out got %h want 000c", o); end
    if (c !== 1'b0)     begin n_fail++; $display("FAIL post_abort_carry got %b want 0", c); end
    if (lat != 3)       begin n_fail++; $display("FAIL post_abort_latency got %0d want 3", lat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] o; logic c; int lat, bc, acc1, acc2;
    do_op(1'b0, 2'b00, 16'h4001, 4'd2, o, c, lat, bc, acc1);
    n_checks += 2;
    if (o !== 16'h0004) begin n_fail++; $display("FAIL b2b_first_out got %h want 0004", o); end
    if (c !== 1'b1)     begin n_fail++; $display("FAIL b2b_first_carry got %b want 1", c); end
    do_op(1'b0, 2'b01, 16'h0003, 4'd1, o, c, lat, bc, acc2);
    n_checks += 3;
    if (acc2 - acc1 != 4) begin n_fail++; $display("FAIL b2b_issue_gap got %0d want 4", acc2 - acc1); end
    if (o !== 16'h0001)   begin n_fail++; $display("FAIL b2b_second_out got %h want 0001", o); end
    if (c !== 1'b1)       begin n_fail++; $display("FAIL b2b_second_carry got %b want 1", c); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_sll_basic();
    test_sra();
    test_rol_srl();
    test_zero_shamt();
    test_start_while_busy();
    test_step4();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
